// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command framer
package uart_cmd_pkg;
  typedef enum logic {IDLE, RCV} framer_state_t;
  localparam int FRAME_BYTES = 4;
  localparam int DEFAULT_TO_CYCLES = 52083;
endpackage

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: assembles 4-byte opcode/data/checksum frames from the UART receiver
//   clk, rst            : clock, synchronous active-high reset
//   rx_rdy, rx_data     : byte-available flag and byte from the receiver
//   clr_rdy             : one-cycle acknowledge back to the receiver
//   clr_cmd_rdy         : dispatcher acknowledge, clears cmd_rdy
//   cmd, data, cmd_rdy  : last good frame and its sticky valid flag
//   chk_err, to_err     : one-cycle checksum / inter-byte timeout pulses
module uart_cmd_framer
  import uart_cmd_pkg::*;
#(
  parameter int TO_CYCLES = DEFAULT_TO_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  input  logic        clr_cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  output logic        chk_err,
  output logic        to_err
);
  localparam int TW = $clog2(TO_CYCLES);
  framer_state_t state;
  logic [1:0]    byte_cnt;
  logic [7:0]    acc;
  logic [7:0]    op;
  logic [15:0]   sr;
  logic [TW-1:0] timer;
  logic          accept;
  logic [7:0]    sum;
  assign accept = rx_rdy & ~clr_rdy;
  assign sum    = acc + rx_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      acc      <= '0;
      op       <= '0;
      sr       <= '0;
      timer    <= '0;
      clr_rdy  <= 1'b0;
      cmd      <= '0;
      data     <= '0;
      cmd_rdy  <= 1'b0;
      chk_err  <= 1'b0;
      to_err   <= 1'b0;
    end else begin
      clr_rdy <= accept;
      chk_err <= 1'b0;
      to_err  <= 1'b0;
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          op       <= rx_data;
          acc      <= rx_data;
          byte_cnt <= 2'd1;
          timer    <= '0;
          cmd_rdy  <= 1'b0;
          state    <= RCV;
        end
      end else if (accept) begin
        if (byte_cnt == 2'(FRAME_BYTES - 1)) begin
          if (sum == 8'h00) begin
            cmd     <= op;
            data    <= sr;
            cmd_rdy <= 1'b1;
          end else begin
            chk_err <= 1'b1;
          end
          byte_cnt <= '0;
          state    <= IDLE;
        end else begin
          sr       <= {sr[7:0], rx_data};
          acc      <= sum;
          byte_cnt <= byte_cnt + 2'd1;
          timer    <= '0;
        end
      end else begin
        // the pulse lands in the same cycle the timer reaches TO_CYCLES-1
        timer <= (timer == {TW{1'b1}}) ? timer : timer + 1'b1;
        if (timer == TW'(TO_CYCLES - 2)) begin
          to_err   <= 1'b1;
          byte_cnt <= '0;
          state    <= IDLE;
        end
      end
    end
  end
endmodule
